mem_controller: RTL and testbench

Two-port memory requester that sits between the CPU-side instruction and data ports and the single-ported RAM. It arbitrates between the two ports and latches the winning request. It drives the RAM request lines stable until the RAM reports ACCESS, then returns load data and releases the wait to the granted port. It is the initiator end of the CPU–RAM interface.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/mem_controller_if.sv | 39 +++
 rtl/mem_controller_arb.sv | 27 ++
 rtl/mem_controller.sv | 124 ++++++++++++
 tb/tb_mem_controller.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: data word, RAM handshake state and memory-controller FSM states.
// No logic; types only.
// Imported by the memory controller, its arbiter and the CPU-RAM interface.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC_I = 2'd1,
      ACC_D = 2'd2
   } memctrl_state_t;

endpackage

// File: rtl/mem_controller_if.sv
// CPU instruction/data ports plus RAM request lines, bundled for the memory controller.
// Purely wires; no latency.
// Waits are the only flow control: a requester holds its request until its wait drops.
interface mem_controller_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;

   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   logic      err;

   // controller side
   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   // CPU + RAM side (environment)
   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_controller_arb.sv
// Two-way round-robin grant between instruction and data requests.
// Grant is combinational; the "last served" bit updates on access completion.
// Holds no requests itself; a losing port simply stays pending.
module mem_arbiter_rr (
   input  logic CLK,
   input  logic nRST,
   input  logic i_req_i,
   input  logic i_req_d,
   input  logic i_done,
   input  logic i_done_d,
   output logic o_gnt_i,
   output logic o_gnt_d
);
   // 1 = data port was served last; resets to instruction so the first tie goes to data
   logic r_last_d;

   assign o_gnt_d = i_req_d & (~i_req_i | ~r_last_d);
   assign o_gnt_i = i_req_i & (~i_req_d |  r_last_d);

   // remember which port finished most recently
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_last_d <= 1'b0;
      else if (i_done)
         r_last_d <= i_done_d;
   end
endmodule

// File: rtl/mem_controller.sv
// Arbitrates CPU instruction/data ports onto one RAM port; MEMCTRL_TIMEOUT_EN adds an access timeout.
// Latency: 1 cycle to grant + RAM latency; at least one idle cycle between accesses.
// Backpressure: iwait/dwait stay high until the granted access sees ACCESS (or times out).
module mem_controller
   import cpu_types_pkg::*;
#(
   parameter word_t BAD     = 32'hBAD1BAD1,
   parameter int    TIMEOUT = 16
) (
   input  logic CLK,
   input  logic nRST,
   mem_controller_if.master bus
);
   memctrl_state_t r_state;
   memctrl_state_t w_next;
   word_t          r_addr;
   word_t          r_store;
   logic           r_wen;

   logic w_req_i, w_req_d, w_gnt_i, w_gnt_d;
   logic w_access, w_tmo, w_done;

   assign w_req_i  = bus.iREN;
   assign w_req_d  = bus.dREN | bus.dWEN;
   assign w_access = (bus.ramstate == ACCESS);

`ifdef MEMCTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] r_cnt;

   // count cycles spent in the current access; IDLE clears it so it restarts on entry
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_cnt <= '0;
      else if (r_state == IDLE)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

   // ACCESS arriving in the final cycle takes priority over the abort
   assign w_tmo = (r_state != IDLE) && !w_access && (r_cnt == CW'(TIMEOUT - 1));
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^TIMEOUT;
   assign w_tmo        = 1'b0;
`endif

   assign w_done = (r_state != IDLE) && (w_access || w_tmo);

   mem_arbiter_rr u_arb (
      .CLK      (CLK),
      .nRST     (nRST),
      .i_req_i  (w_req_i),
      .i_req_d  (w_req_d),
      .i_done   (w_done),
      .i_done_d (r_state == ACC_D),
      .o_gnt_i  (w_gnt_i),
      .o_gnt_d  (w_gnt_d)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // latch the winning request so RAM lines stay constant for the whole access
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_addr  <= '0;
         r_store <= '0;
         r_wen   <= 1'b0;
      end else if (r_state == IDLE && (w_gnt_i || w_gnt_d)) begin
         r_addr <= w_gnt_d ? bus.daddr : bus.iaddr;
         r_wen  <= w_gnt_d & bus.dWEN;
         if (w_gnt_d)
            r_store <= bus.dstore;
      end
   end

   assign bus.ramaddr  = r_addr;
   assign bus.ramstore = r_store;
   assign bus.err      = w_tmo;

   // next state, RAM enables, waits and load data
   always_comb begin
      w_next     = r_state;
      bus.iwait  = w_req_i;
      bus.dwait  = w_req_d;
      bus.iload  = '0;
      bus.dload  = '0;
      bus.ramREN = 1'b0;
      bus.ramWEN = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_gnt_d)
               w_next = ACC_D;
            else if (w_gnt_i)
               w_next = ACC_I;
         end
         ACC_I: begin
            bus.ramREN = 1'b1;
            if (w_done) begin
               bus.iwait = 1'b0;
               bus.iload = w_access ? bus.ramload : BAD;
               w_next    = IDLE;
            end
         end
         ACC_D: begin
            bus.ramREN = ~r_wen;
            bus.ramWEN = r_wen;
            if (w_done) begin
               bus.dwait = 1'b0;
               bus.dload = w_access ? bus.ramload : BAD;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: per-cycle vector table plus tie, reset and timeout sequences.
// Inputs change 2 time units after the rising edge; outputs are sampled 2 units later.
// Works with MEMCTRL_TIMEOUT_EN either defined or undefined.
module tb_mem_controller;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic nRST;
   int   checks = 0;
   int   errors = 0;

   mem_controller_if bus ();

   mem_controller dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic      iren;
      word_t     iaddr;
      logic      dren;
      logic      dwen;
      word_t     daddr;
      word_t     dstore;
      ramstate_t rs;
      word_t     rload;
      logic      e_iwait;
      logic      e_dwait;
      logic      e_ren;
      logic      e_wen;
      word_t     e_addr;
      word_t     e_store;
      word_t     e_iload;
      word_t     e_dload;
   } vec_t;

   localparam word_t DB = 32'hDEADBEEF;
   localparam word_t CF = 32'hCAFEF00D;
   localparam int    NV = 19;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.iREN     = v.iren;
      bus.iaddr    = v.iaddr;
      bus.dREN     = v.dren;
      bus.dWEN     = v.dwen;
      bus.daddr    = v.daddr;
      bus.dstore   = v.dstore;
      bus.ramstate = v.rs;
      bus.ramload  = v.rload;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int err_cnt;
      int bad_cnt;

      //         iren  iaddr        dren  dwen  daddr        dstore  rs      rload          iw    dw    ren   wen   addr         store  iload          dload
      vecs[0]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0, FREE,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0,        32'h0};
      vecs[1]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0, BUSY,   32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0, 32'h0,        32'h0};
      vecs[2]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0, ACCESS, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0, 32'h12345678, 32'h0};
      vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0, FREE,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0, 32'h0,        32'h0};
      vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h100, DB,    FREE,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h40,  32'h0, 32'h0,        32'h0};
      vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h100, DB,    ACCESS, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, DB,    32'h0,        32'h5A5A5A5A};
      vecs[6]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   DB,    FREE,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h100, DB,    32'h0,        32'h0};
      vecs[7]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h300, DB,    FREE,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h100, DB,    32'h0,        32'h0};
      vecs[8]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h300, DB,    ACCESS, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, DB,    32'h11111111, 32'h0};
      vecs[9]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h300, DB,    FREE,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h200, DB,    32'h0,        32'h0};
      vecs[10] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h300, DB,    ACCESS, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, DB,    32'h0,        32'h22222222};
      vecs[11] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h300, DB,    FREE,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h300, DB,    32'h0,        32'h0};
      vecs[12] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h300, DB,    BUSY,   32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h200, DB,    32'h0,        32'h0};
      vecs[13] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h300, DB,    ACCESS, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, DB,    32'h33333333, 32'h0};
      vecs[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   DB,    FREE,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h200, DB,    32'h0,        32'h0};
      vecs[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  CF,    FREE,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h200, DB,    32'h0,        32'h0};
      vecs[16] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  CF,    ERROR,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h44,  CF,    32'h0,        32'h0};
      vecs[17] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  CF,    ACCESS, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h44,  CF,    32'h0,        32'h0};
      vecs[18] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0, FREE,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h44,  CF,    32'h0,        32'h0};

      // reset state
      nRST = 1'b0;
      drive(vecs[18]);
      repeat (2) @(posedge CLK);
      #2;
      chk("reset", 160'({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err,
                         bus.ramaddr, bus.ramstore, bus.iload, bus.dload}), 160'(0));
      #1 nRST = 1'b1;

      // per-cycle vector table
      for (int i = 0; i < NV; i++) begin
         @(posedge CLK);
         #2 drive(vecs[i]);
         #2 chk($sformatf("vec%0d", i),
                160'({bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err,
                      bus.ramaddr, bus.ramstore, bus.iload, bus.dload}),
                160'({vecs[i].e_iwait, vecs[i].e_dwait, vecs[i].e_ren, vecs[i].e_wen, 1'b0,
                      vecs[i].e_addr, vecs[i].e_store, vecs[i].e_iload, vecs[i].e_dload}));
      end

      // tie after reset with a zero-wait RAM: D, I, D, I with an idle cycle between each
      @(posedge CLK);
      #2 nRST = 1'b0;
      bus.iREN = 1'b1; bus.iaddr = 32'hA0;
      bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'hD0;
      bus.ramstate = FREE;
      #1 nRST = 1'b1;
      #1 chk("tie_c0", 160'({bus.ramREN, bus.iwait, bus.dwait}), 160'(3'b011));
      for (int c = 1; c <= 8; c++) begin
         @(posedge CLK);
         #2 bus.ramstate = (bus.ramREN || bus.ramWEN) ? ACCESS : FREE;
         #2;
         if (c % 2 == 1) begin
            logic dturn;
            dturn = (c == 1) || (c == 5);
            chk($sformatf("tie_c%0d", c),
                160'({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr}),
                160'({1'b1, 1'b0, dturn, ~dturn, dturn ? 32'hD0 : 32'hA0}));
         end else begin
            chk($sformatf("tie_c%0d", c),
                160'({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}), 160'(4'b0011));
         end
      end

      // reset in the middle of an instruction access, then re-grant
      bus.dREN = 1'b0; bus.iaddr = 32'h80; bus.ramstate = BUSY; bus.ramload = 32'hFACE0080;
      @(posedge CLK);
      #2 chk("rst_pre", 160'({bus.ramREN, bus.ramaddr}), 160'({1'b1, 32'h80}));
      #1 nRST = 1'b0;
      #1 chk("rst_async", 160'({bus.ramREN, bus.ramWEN, bus.iwait, bus.ramaddr}),
             160'({1'b0, 1'b0, 1'b1, 32'h0}));
      #2 nRST = 1'b1;
      #1 chk("rst_idle", 160'({bus.ramREN, bus.ramaddr}), 160'({1'b0, 32'h0}));
      @(posedge CLK);
      #2 chk("rst_regrant", 160'({bus.ramREN, bus.ramaddr}), 160'({1'b1, 32'h80}));
      bus.ramstate = ACCESS;
      #1 chk("rst_done", 160'({bus.iwait, bus.iload}), 160'({1'b0, 32'hFACE0080}));
      @(posedge CLK);
      #2 bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = 32'h0;

      // RAM that never answers
      bus.dREN = 1'b1; bus.daddr = 32'hC0; bus.ramstate = BUSY;
      err_cnt = 0;
      bad_cnt = 0;
`ifdef MEMCTRL_TIMEOUT_EN
      for (int k = 1; k <= 17; k++) begin
         @(posedge CLK);
         #2;
         if (bus.err) err_cnt++;
         if (k < 16) begin
            if (bus.dwait !== 1'b1 || bus.err !== 1'b0 || bus.ramREN !== 1'b1) bad_cnt++;
         end else if (k == 16) begin
            chk("tmo_abort", 160'({bus.dwait, bus.err, bus.dload}), 160'({1'b0, 1'b1, 32'hBAD1BAD1}));
            bus.dREN = 1'b0;
         end else begin
            chk("tmo_idle", 160'({bus.ramREN, bus.dwait, bus.err}), 160'(3'b000));
         end
      end
      chk("tmo_wait_cycles", 160'(bad_cnt), 160'(0));
      chk("tmo_err_pulses", 160'(err_cnt), 160'(1));
`else
      for (int k = 1; k <= 100; k++) begin
         @(posedge CLK);
         #2;
         if (bus.err) err_cnt++;
         if (bus.dwait !== 1'b1 || bus.ramREN !== 1'b1) bad_cnt++;
      end
      chk("notmo_wait", 160'(bad_cnt), 160'(0));
      chk("notmo_err", 160'(err_cnt), 160'(0));
      bus.dREN = 1'b0;
      nRST = 1'b0;
      #1 nRST = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
